rf_write_scheduler: RTL and testbench

- Owns the single write port of the 8x8 register file. It shares that port among NREQ writeback requesters (ALU, load unit, move/immediate path) using a valid/ready handshake and round-robin arbitration.
- It also runs a clear sequence that zeroes all 8 registers on command, because the register file itself has no reset.
- It sits between the writeback sources and the register file's regWrite / writeReg / writeData inputs. All outputs to the register file are registered.

---
 rtl/rf_write_scheduler.sv | 121 ++++++++++++
 tb/tb_rf_write_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rf_write_scheduler.sv
// Write-port owner for the 8x8 register file: round-robin arbitration among
// writeback requesters plus a zero-fill clear sequence, with registered rf_* outputs.
module rf_write_scheduler #(
    parameter int NREQ  = 3,
    parameter int NREGS = 8,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*3-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic                    clear_done,
    output logic                    rf_regWrite,
    output logic [2:0]              rf_writeReg,
    output logic [DW-1:0]           rf_writeData,
    output logic                    fsm_state
);

    localparam int AW = 3;
    localparam int PW = (NREQ > 2) ? 2 : 1;

    // Handshake: a requester holds req_valid/addr/data stable until the cycle in
    // which req_ready is also high; that cycle is the accept, and the write is
    // presented on rf_* in the following cycle.

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   rr_ptr;
    logic [AW-1:0]   clr_cnt;
    logic            accept;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            clr_last;

    assign clr_last   = (clr_cnt == AW'(NREGS - 1));
    assign clear_busy = rst_n && (state == CLEAR);
    assign fsm_state  = state;

    always_comb begin
        int idx;
        idx        = 0;
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        win_idx    = '0;
        sel_addr   = '0;
        sel_data   = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        // clear pre-empts every pending request this cycle
                        state_next = CLEAR;
                    end else begin
                        for (int k = 0; k < NREQ; k++) begin
                            idx = (int'(rr_ptr) + k) % NREQ;
                            if (!accept && req_valid[idx]) begin
                                accept         = 1'b1;
                                win_idx        = PW'(idx);
                                req_ready[idx] = 1'b1;
                                sel_addr       = req_addr[AW*idx +: AW];
                                sel_data       = req_data[DW*idx +: DW];
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            clr_cnt      <= '0;
            rf_regWrite  <= 1'b0;
            rf_writeReg  <= '0;
            rf_writeData <= '0;
            clear_done   <= 1'b0;
        end else begin
            state       <= state_next;
            rf_regWrite <= 1'b0;
            clear_done  <= 1'b0;
            if (state == CLEAR) begin
                rf_regWrite  <= 1'b1;
                rf_writeReg  <= clr_cnt;
                rf_writeData <= '0;
                if (clr_last) begin
                    clr_cnt    <= '0;
                    clear_done <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else if (clear_start) begin
                clr_cnt <= '0;
            end else if (accept) begin
                rf_regWrite  <= 1'b1;
                rf_writeReg  <= sel_addr;
                rf_writeData <= sel_data;
                rr_ptr       <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: vector table for arbitration, hand sequences for
// clear / clear-vs-request / reset-mid-clear, and a per-cycle expected-output queue.
module tb_rf_write_scheduler;

    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int W    = 13;   // {clear_done, rf_regWrite, rf_writeReg[2:0], rf_writeData[7:0]}

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*3-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              rf_regWrite;
    logic [2:0]        rf_writeReg;
    logic [DW-1:0]     rf_writeData;
    logic              fsm_state;

    rf_write_scheduler #(.NREQ(NREQ), .NREGS(8), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .rf_regWrite  (rf_regWrite),
        .rf_writeReg  (rf_writeReg),
        .rf_writeData (rf_writeData),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           m_clr  = -1;      // next clear address, -1 when not clearing
    logic [2:0]   h_addr = '0;
    logic [7:0]   h_data = '0;

    typedef struct {
        logic        rn;
        logic [2:0]  v;
        logic [8:0]  a;
        logic [23:0] d;
        logic        cs;
        logic [2:0]  er;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare at negedge, predict the next registered outputs.
    task automatic cycle(input logic rn, input logic [2:0] v, input logic [8:0] a,
                         input logic [23:0] d, input logic cs, input logic [2:0] er);
        logic [W-1:0] e;
        int g;
        rst_n       = rn;
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        clear_start = cs;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_out", {3'b000, clear_done, rf_regWrite, rf_writeReg, rf_writeData}, {3'b000, e});
        end
        check("req_ready", 16'(req_ready), 16'(er));
        check("clear_busy", 16'(clear_busy), 16'(rn && (m_clr >= 0)));
        if (!rn) begin
            h_addr = '0;
            h_data = '0;
            m_clr  = -1;
            exp_q.push_back({2'b00, 3'd0, 8'd0});
        end else if (m_clr >= 0) begin
            h_addr = 3'(m_clr);
            h_data = '0;
            exp_q.push_back({(m_clr == 7), 1'b1, h_addr, h_data});
            m_clr = (m_clr == 7) ? -1 : m_clr + 1;
        end else if (cs) begin
            exp_q.push_back({2'b00, h_addr, h_data});
            m_clr = 0;
        end else if (er != 3'b000) begin
            g      = er[0] ? 0 : (er[1] ? 1 : 2);
            h_addr = a[3*g +: 3];
            h_data = d[8*g +: 8];
            exp_q.push_back({2'b01, h_addr, h_data});
        end else begin
            exp_q.push_back({2'b00, h_addr, h_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;

        tbl[0]  = '{1'b0, 3'b111, 9'o000, 24'h000000, 1'b0, 3'b000};
        tbl[1]  = '{1'b0, 3'b000, 9'o000, 24'h000000, 1'b0, 3'b000};
        tbl[2]  = '{1'b1, 3'b000, 9'o000, 24'h000000, 1'b0, 3'b000};
        tbl[3]  = '{1'b1, 3'b010, 9'o050, 24'h00A700, 1'b0, 3'b010};
        tbl[4]  = '{1'b1, 3'b000, 9'o000, 24'h000000, 1'b0, 3'b000};
        tbl[5]  = '{1'b1, 3'b011, 9'o000, 24'h000000, 1'b0, 3'b001};
        tbl[6]  = '{1'b1, 3'b011, 9'o000, 24'h000000, 1'b0, 3'b010};
        tbl[7]  = '{1'b1, 3'b101, 9'o000, 24'h000000, 1'b0, 3'b100};
        tbl[8]  = '{1'b1, 3'b110, 9'o000, 24'h000000, 1'b0, 3'b010};
        tbl[9]  = '{1'b1, 3'b001, 9'o000, 24'h000000, 1'b0, 3'b001};
        tbl[10] = '{1'b1, 3'b100, 9'o000, 24'h000000, 1'b0, 3'b100};
        for (int i = 5; i < 11; i++) begin
            tbl[i].a = 9'($urandom_range(0, 511));
            tbl[i].d = 24'($urandom);
        end

        @(posedge clk);
        #1;
        exp_q.push_back('0);

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rn, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].cs, tbl[i].er);
        end

        repeat (10) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);

        // fairness straight out of reset
        cycle(1'b0, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'b111, 9'o765, 24'h332211, 1'b0, 3'(1 << (i % 3)));
        end
        cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);

        // plain clear
        cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b1, 3'b000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        repeat (2) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);

        // clear with requester 0 waiting; a stray clear_start mid-sequence is ignored
        cycle(1'b1, 3'b001, 9'o006, 24'h00005C, 1'b1, 3'b000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'b001, 9'o006, 24'h00005C, (i == 3), 3'b000);
        cycle(1'b1, 3'b001, 9'o006, 24'h00005C, 1'b0, 3'b001);
        cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);

        // reset while the 4th zero-write is on the port, then a full clear again
        cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b1, 3'b000);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        cycle(1'b0, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        repeat (3) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b1, 3'b000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);
        repeat (2) cycle(1'b1, 3'b000, 9'o000, 24'h0, 1'b0, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
